spi_slave_frame: RTL and testbench

Parametrised SPI slave front end for the register/memory wrapper. It deserialises command frames of DATA_W+2 bits from `MOSI` and issues the received word on `rx_data` with a one-cycle `rx_valid` pulse. For read-data commands it waits for the wrapper's `tx_data`/`tx_valid` and serialises DATA_W bits back on `MISO`. Compared with the fixed 8-bit slave it adds a data-width parameter, a bounded wait for read data, mid-frame abort detection, and a clean post-frame hold state.

---
 rtl/spi_pkg.sv | 34 +++
 rtl/spi_tx_shifter.sv | 68 ++++++
 rtl/spi_slave_frame.sv | 201 ++++++++++++++++++++
 tb/tb_spi_slave_frame.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave frame front end.
// Holds the FSM state encoding, the 2-bit command codes carried in the
// first two bits of every frame, and a helper that classifies a command.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CHK_CMD   = 3'd1,
    ST_WRITE     = 3'd2,
    ST_READ_ADDR = 3'd3,
    ST_READ_DATA = 3'd4,
    ST_TX_WAIT   = 3'd5,
    ST_TX_SHIFT  = 3'd6,
    ST_DONE      = 3'd7
  } spi_state_e;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  // True for the two read commands. Only cmd[1] is known when the decision
  // is taken, so callers pass {cmd[1], 1'b0}.
  function automatic logic cmd_is_read(input logic [1:0] cmd);
    logic r;
    case (cmd)
      CMD_WR_ADDR, CMD_WR_DATA: r = 1'b0;
      CMD_RD_ADDR, CMD_RD_DATA: r = 1'b1;
      default:                  r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/spi_tx_shifter.sv
// Load/shift register that serialises a DATA_W-bit read word onto MISO.
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   load         capture load_data; its MSB appears on miso the next cycle
//   shift        present the next bit (MSB first); zero once the word is out
//   clear        drop the word and force miso to 0
//   load_data    word to serialise
//   miso         registered serial output, 0 when idle
//   done         high while the last (LSB) bit is on miso
module spi_tx_shifter #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift,
  input  logic              clear,
  input  logic [DATA_W-1:0] load_data,
  output logic              miso,
  output logic              done
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] sh_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              active_r;
  logic              miso_r;

  // Shift register, bits-remaining counter and the MISO output flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_r     <= '0;
      cnt_r    <= '0;
      active_r <= 1'b0;
      miso_r   <= 1'b0;
    end else if (clear) begin
      sh_r     <= '0;
      cnt_r    <= '0;
      active_r <= 1'b0;
      miso_r   <= 1'b0;
    end else if (load) begin
      // MSB goes straight to the output flop; the rest waits in sh_r.
      miso_r   <= load_data[DATA_W-1];
      sh_r     <= load_data << 1;
      cnt_r    <= CNT_W'(DATA_W - 1);
      active_r <= 1'b1;
    end else if (shift && active_r) begin
      if (cnt_r == '0) begin
        miso_r   <= 1'b0;
        active_r <= 1'b0;
      end else begin
        miso_r <= sh_r[DATA_W-1];
        sh_r   <= sh_r << 1;
        cnt_r  <= cnt_r - CNT_W'(1);
      end
    end else begin
      sh_r     <= sh_r;
      cnt_r    <= cnt_r;
      active_r <= active_r;
      miso_r   <= miso_r;
    end
  end

  assign miso = miso_r;
  assign done = active_r && (cnt_r == '0);

endmodule

// File: rtl/spi_slave_frame.sv
// SPI slave front end: deserialises {cmd[1:0], payload} frames from MOSI,
// reports each complete frame with a one-cycle rx_valid pulse and, for
// read-data commands, waits (bounded) for tx_data and serialises it on MISO.
// Ports:
//   clk, rst    system/bit clock, synchronous active-high reset
//   SS_n        slave select, active low; high mid-frame aborts the frame
//   MOSI        serial input, MSB first
//   MISO        serial output, MSB first, 0 when not shifting
//   rx_data     last complete frame {cmd, payload}
//   rx_valid    one-cycle pulse when rx_data updates
//   tx_data     read payload, sampled with tx_valid while waiting
//   tx_valid    read payload valid
//   frame_err   one-cycle pulse on abort or read-data timeout
//   busy        registered, high whenever the FSM is not idle
module spi_slave_frame
  import spi_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int TX_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              frame_err,
  output logic              busy
);

  localparam int N      = DATA_W + 2;
  localparam int BIT_W  = $clog2(N + 1);
  localparam int WAIT_W = (TX_TIMEOUT > 0) ? $clog2(TX_TIMEOUT + 1) : 1;
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(N - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = (TX_TIMEOUT > 0) ? WAIT_W'(TX_TIMEOUT - 1) : '0;

  spi_state_e        state_r, state_nxt_s;
  logic [N-2:0]      rx_sh_r, rx_sh_nxt_s;
  logic [BIT_W-1:0]  bit_cnt_r, bit_cnt_nxt_s;
  logic [WAIT_W-1:0] wait_cnt_r, wait_cnt_nxt_s;
  logic              rd_seen_r, rd_seen_nxt_s;
  logic [N-1:0]      rx_data_r, rx_data_nxt_s;
  logic              rx_valid_r, rx_valid_nxt_s;
  logic              frame_err_r, frame_err_nxt_s;
  logic              busy_r;
  logic              tx_load_s, tx_shift_s, tx_clear_s, tx_done_s, miso_s;

  // Next-state, counters and pulse outputs; SS_n high wins over everything.
  always_comb begin
    state_nxt_s     = state_r;
    rx_sh_nxt_s     = rx_sh_r;
    bit_cnt_nxt_s   = bit_cnt_r;
    wait_cnt_nxt_s  = wait_cnt_r;
    rd_seen_nxt_s   = rd_seen_r;
    rx_data_nxt_s   = rx_data_r;
    rx_valid_nxt_s  = 1'b0;
    frame_err_nxt_s = 1'b0;
    tx_load_s       = 1'b0;
    tx_shift_s      = 1'b0;
    tx_clear_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!SS_n) begin
          state_nxt_s   = ST_CHK_CMD;
          rx_sh_nxt_s   = '0;
          bit_cnt_nxt_s = '0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CHK_CMD: begin
        if (SS_n) begin
          state_nxt_s     = ST_IDLE;
          frame_err_nxt_s = 1'b1;
        end else begin
          rx_sh_nxt_s   = {rx_sh_r[N-3:0], MOSI};
          bit_cnt_nxt_s = BIT_W'(1);
          if (!cmd_is_read({MOSI, 1'b0})) begin
            state_nxt_s = ST_WRITE;
          end else if (rd_seen_r) begin
            state_nxt_s = ST_READ_DATA;
          end else begin
            state_nxt_s = ST_READ_ADDR;
          end
        end
      end
      ST_WRITE, ST_READ_ADDR, ST_READ_DATA: begin
        if (SS_n) begin
          // Also covers SS_n rising together with the last bit: no rx_valid.
          state_nxt_s     = ST_IDLE;
          frame_err_nxt_s = 1'b1;
        end else if (bit_cnt_r == BIT_LAST) begin
          rx_data_nxt_s  = {rx_sh_r, MOSI};
          rx_valid_nxt_s = 1'b1;
          bit_cnt_nxt_s  = '0;
          wait_cnt_nxt_s = '0;
          if (state_r == ST_READ_DATA) begin
            state_nxt_s = ST_TX_WAIT;
          end else if (state_r == ST_READ_ADDR) begin
            state_nxt_s   = ST_DONE;
            rd_seen_nxt_s = 1'b1;
          end else begin
            state_nxt_s = ST_DONE;
          end
        end else begin
          rx_sh_nxt_s   = {rx_sh_r[N-3:0], MOSI};
          bit_cnt_nxt_s = bit_cnt_r + BIT_W'(1);
        end
      end
      ST_TX_WAIT: begin
        if (SS_n) begin
          state_nxt_s     = ST_IDLE;
          frame_err_nxt_s = 1'b1;
          rd_seen_nxt_s   = 1'b0;
        end else if (tx_valid) begin
          tx_load_s   = 1'b1;
          state_nxt_s = ST_TX_SHIFT;
        end else if ((TX_TIMEOUT != 0) && (wait_cnt_r == WAIT_LAST)) begin
          // This edge is the TX_TIMEOUT-th one without tx_valid.
          frame_err_nxt_s = 1'b1;
          rd_seen_nxt_s   = 1'b0;
          state_nxt_s     = ST_DONE;
        end else begin
          wait_cnt_nxt_s = wait_cnt_r + WAIT_W'(1);
        end
      end
      ST_TX_SHIFT: begin
        if (SS_n) begin
          state_nxt_s     = ST_IDLE;
          frame_err_nxt_s = 1'b1;
          rd_seen_nxt_s   = 1'b0;
          tx_clear_s      = 1'b1;
        end else if (tx_done_s) begin
          state_nxt_s   = ST_DONE;
          rd_seen_nxt_s = 1'b0;
          tx_clear_s    = 1'b1;
        end else begin
          tx_shift_s = 1'b1;
        end
      end
      ST_DONE: begin
        if (SS_n) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, counters, captured frame and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      rx_sh_r     <= '0;
      bit_cnt_r   <= '0;
      wait_cnt_r  <= '0;
      rd_seen_r   <= 1'b0;
      rx_data_r   <= '0;
      rx_valid_r  <= 1'b0;
      frame_err_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      rx_sh_r     <= rx_sh_nxt_s;
      bit_cnt_r   <= bit_cnt_nxt_s;
      wait_cnt_r  <= wait_cnt_nxt_s;
      rd_seen_r   <= rd_seen_nxt_s;
      rx_data_r   <= rx_data_nxt_s;
      rx_valid_r  <= rx_valid_nxt_s;
      frame_err_r <= frame_err_nxt_s;
      busy_r      <= (state_nxt_s != ST_IDLE);
    end
  end

  spi_tx_shifter #(
    .DATA_W (DATA_W)
  ) u_tx (
    .clk       (clk),
    .rst       (rst),
    .load      (tx_load_s),
    .shift     (tx_shift_s),
    .clear     (tx_clear_s),
    .load_data (tx_data),
    .miso      (miso_s),
    .done      (tx_done_s)
  );

  assign MISO      = miso_s;
  assign rx_data   = rx_data_r;
  assign rx_valid  = rx_valid_r;
  assign frame_err = frame_err_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_spi_slave_frame.sv
// Directed bench for spi_slave_frame. Two instances: A (DATA_W=8,
// TX_TIMEOUT=4) and B (DATA_W=16, TX_TIMEOUT=16). Each frame task derives the
// expected per-edge outputs from the frame-level timing rules and the
// compare process checks every cycle after the first clock edge.
module tb_spi_slave_frame;

  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rst_v, ss_v, mosi_v, txv_v;
  logic [7:0]  txd_a;
  logic [15:0] txd_b;
  logic        miso_a, rxv_a, err_a, busy_a;
  logic [9:0]  rxd_a;
  logic        miso_b, rxv_b, err_b, busy_b;
  logic [17:0] rxd_b;

  spi_slave_frame #(.DATA_W(8), .TX_TIMEOUT(4)) dut_a (
    .clk(clk), .rst(rst_v[0]), .SS_n(ss_v[0]), .MOSI(mosi_v[0]), .MISO(miso_a),
    .rx_data(rxd_a), .rx_valid(rxv_a), .tx_data(txd_a), .tx_valid(txv_v[0]),
    .frame_err(err_a), .busy(busy_a));

  spi_slave_frame #(.DATA_W(16), .TX_TIMEOUT(16)) dut_b (
    .clk(clk), .rst(rst_v[1]), .SS_n(ss_v[1]), .MOSI(mosi_v[1]), .MISO(miso_b),
    .rx_data(rxd_b), .rx_valid(rxv_b), .tx_data(txd_b), .tx_valid(txv_v[1]),
    .frame_err(err_b), .busy(busy_b));

  int total = 0;
  int bad = 0;
  int edge_n = 0;

  bit          exp_rxv  [2][DEPTH];
  bit          exp_err  [2][DEPTH];
  bit          exp_miso [2][DEPTH];
  bit          exp_busy [2][DEPTH];
  bit          exp_rst  [2][DEPTH];
  logic [17:0] exp_rxd  [2][DEPTH];
  logic [17:0] mdl_rxd  [2];
  bit          seen     [2];
  logic [15:0] miso_hist = 16'h0000;

  // Index of the most recent rising edge.
  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic cmp(input string name, input int s, input logic [17:0] act, input logic [17:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst=%0d edge=%0d got=%h want=%h", name, s, edge_n, act, exp);
    end
  endtask

  task automatic check_inst(input int s, input logic rxv, input logic err, input logic miso,
                            input logic bsy, input logic [17:0] rxd);
    int c;
    c = edge_n;
    if (exp_rst[s][c]) mdl_rxd[s] = 18'd0;
    if (exp_rxv[s][c]) mdl_rxd[s] = exp_rxd[s][c];
    cmp("rx_valid",  s, 18'(rxv),  18'(exp_rxv[s][c]));
    cmp("frame_err", s, 18'(err),  18'(exp_err[s][c]));
    cmp("miso",      s, 18'(miso), 18'(exp_miso[s][c]));
    cmp("busy",      s, 18'(bsy),  18'(exp_busy[s][c]));
    cmp("rx_data",   s, rxd, mdl_rxd[s]);
  endtask

  // Per-cycle comparison of both instances, away from the active edge.
  always @(negedge clk) begin
    if (edge_n >= 1 && edge_n < DEPTH) begin
      check_inst(0, rxv_a, err_a, miso_a, busy_a, {8'd0, rxd_a});
      check_inst(1, rxv_b, err_b, miso_b, busy_b, rxd_b);
      miso_hist <= {miso_hist[14:0], miso_a};
    end
  end

  task automatic mark_busy(input int s, input int a, input int b);
    for (int c = a; c <= b; c++) if (c < DEPTH) exp_busy[s][c] = 1'b1;
  endtask

  // Drive one frame on instance s and record what it must produce.
  //   abort_at : frame bit index at which SS_n is seen high (-1 = none)
  //   tx_delay : TX_WAIT edge (1-based) carrying tx_valid (0 = never)
  //   rst_off  : rst sampled this many edges after the tx_valid edge (0 = none)
  //   hold     : extra DONE edges with SS_n low before release
  task automatic run_frame(input int s, input logic [17:0] fr, input int abort_at,
                           input int tx_delay, input logic [15:0] txw,
                           input int rst_off, input int hold);
    int dw, n, tmo, e0, len, ew;
    bit cmd1;
    bit d_ss [64];
    bit d_mosi [64];
    bit d_txv [64];
    bit d_rst [64];
    dw = (s == 0) ? 8 : 16;
    n = dw + 2;
    tmo = (s == 0) ? 4 : 16;
    e0 = edge_n + 1;
    for (int i = 0; i < 64; i++) begin
      d_ss[i] = 1'b1; d_mosi[i] = 1'b0; d_txv[i] = 1'b0; d_rst[i] = 1'b0;
    end
    if (s == 0) txd_a = txw[7:0];
    else        txd_b = txw;
    d_ss[0] = 1'b0;
    for (int k = 0; k < n; k++) begin
      d_mosi[k+1] = fr[n-1-k];
      d_ss[k+1] = 1'b0;
    end
    cmd1 = fr[n-1];
    if (abort_at >= 0) begin
      d_ss[abort_at+1] = 1'b1;
      exp_err[s][e0+abort_at+1] = 1'b1;
      mark_busy(s, e0, e0 + abort_at);
      len = abort_at + 2;
    end else begin
      exp_rxv[s][e0+n] = 1'b1;
      exp_rxd[s][e0+n] = fr;
      if (!cmd1 || !seen[s]) begin
        if (cmd1) seen[s] = 1'b1;
        for (int i = 1; i <= hold; i++) begin
          d_ss[n+i] = 1'b0;
          d_mosi[n+i] = 1'b1;
        end
        mark_busy(s, e0, e0 + n + hold);
        len = n + hold + 2;
      end else if (tx_delay == 0 || tx_delay > tmo) begin
        for (int i = 1; i <= tmo; i++) d_ss[n+i] = 1'b0;
        exp_err[s][e0+n+tmo] = 1'b1;
        seen[s] = 1'b0;
        mark_busy(s, e0, e0 + n + tmo);
        len = n + tmo + 2;
      end else begin
        ew = n + tx_delay;
        for (int i = n + 1; i <= ew + dw; i++) d_ss[i] = 1'b0;
        d_txv[ew] = 1'b1;
        seen[s] = 1'b0;
        if (rst_off > 0) begin
          for (int i = ew + rst_off; i < 64; i++) d_ss[i] = 1'b1;
          d_rst[ew+rst_off] = 1'b1;
          for (int i = 0; i < rst_off; i++) exp_miso[s][e0+ew+i] = txw[dw-1-i];
          exp_rst[s][e0+ew+rst_off] = 1'b1;
          mark_busy(s, e0, e0 + ew + rst_off - 1);
          len = ew + rst_off + 2;
        end else begin
          for (int i = 0; i < dw; i++) exp_miso[s][e0+ew+i] = txw[dw-1-i];
          mark_busy(s, e0, e0 + ew + dw);
          len = ew + dw + 2;
        end
      end
    end
    for (int i = 0; i < len; i++) begin
      ss_v[s] = d_ss[i];
      mosi_v[s] = d_mosi[i];
      txv_v[s] = d_txv[i];
      rst_v[s] = d_rst[i];
      @(posedge clk);
      #1;
    end
    ss_v[s] = 1'b1;
    mosi_v[s] = 1'b0;
    txv_v[s] = 1'b0;
    rst_v[s] = 1'b0;
  endtask

  initial begin
    rst_v = 2'b11; ss_v = 2'b11; mosi_v = 2'b00; txv_v = 2'b00;
    txd_a = 8'h00; txd_b = 16'h0000;
    seen[0] = 1'b0; seen[1] = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      exp_rst[0][c] = 1'b1;
      exp_rst[1][c] = 1'b1;
    end
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst_v = 2'b00;
    @(posedge clk);
    #1;

    // Write frame 00_1010_0101.
    run_frame(0, 18'h000A5, -1, 0, 16'h0000, 0, 0);
    cmp("lit_write", 0, {8'd0, rxd_a}, 18'h000A5);
    // Read-address then read-data with tx_valid on the third wait edge.
    run_frame(0, 18'h00203, -1, 0, 16'h0000, 0, 0);
    cmp("lit_rdaddr", 0, {8'd0, rxd_a}, 18'h00203);
    run_frame(0, 18'h0035A, -1, 3, 16'h00C3, 0, 0);
    cmp("lit_rddata", 0, {8'd0, rxd_a}, 18'h0035A);
    cmp("lit_miso_seq", 0, 18'(miso_hist[8:0]), 18'h00186);
    // rd_addr_seen cleared: an 11 frame is a read-address again.
    run_frame(0, 18'h0030F, -1, 0, 16'h0000, 0, 0);
    // Abort a write frame after bit 5.
    run_frame(0, 18'h001F0, 6, 0, 16'h0000, 0, 0);
    cmp("lit_abort_rx", 0, {8'd0, rxd_a}, 18'h0030F);
    cmp("lit_abort_busy", 0, 18'(busy_a), 18'd0);
    cmp("lit_abort_err", 0, 18'(err_a), 18'd1);
    // Read-data with tx_valid never arriving: timeout after 4 wait edges.
    run_frame(0, 18'h00381, -1, 0, 16'h0000, 0, 0);
    cmp("lit_timeout_rx", 0, {8'd0, rxd_a}, 18'h00381);
    // Reset in the middle of TX_SHIFT.
    run_frame(0, 18'h00201, -1, 0, 16'h0000, 0, 0);
    run_frame(0, 18'h00366, -1, 1, 16'h00A5, 3, 0);
    cmp("lit_reset_rx", 0, {8'd0, rxd_a}, 18'h00000);
    run_frame(0, 18'h003C3, -1, 0, 16'h0000, 0, 0);
    // SS_n rising with the last bit is an abort.
    run_frame(0, 18'h000FF, 9, 0, 16'h0000, 0, 0);
    cmp("lit_lastbit_abort", 0, {8'd0, rxd_a}, 18'h003C3);
    // DONE holds while SS_n stays low and ignores MOSI.
    run_frame(0, 18'h00155, -1, 0, 16'h0000, 0, 2);
    cmp("lit_hold", 0, {8'd0, rxd_a}, 18'h00155);

    // 16-bit payload, back-to-back write frames.
    run_frame(1, 18'h01234, -1, 0, 16'h0000, 0, 0);
    cmp("lit_w16_a", 1, rxd_b, 18'h01234);
    run_frame(1, 18'h1BEEF, -1, 0, 16'h0000, 0, 0);
    cmp("lit_w16_b", 1, rxd_b, 18'h1BEEF);

    repeat (3) begin
      @(posedge clk);
      #1;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
